univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg_pkg.sv | 17 +
 rtl/univ_shift_reg_shreg_cell.sv | 30 +++
 rtl/univ_shift_reg.sv | 94 +++++++++
 tb/tb_univ_shift_reg.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register:
// operation-select encodings and the counter width helper.
package univ_shift_reg_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   // Bits needed to hold a shift count from 0 up to and including w.
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/univ_shift_reg_shreg_cell.sv
// One bit of the universal shift register: 4:1 next-value select
// (hold / right neighbour / left neighbour / parallel data) feeding a
// synchronously reset flop.
module shreg_cell
   import univ_shift_reg_pkg::*;
(
   input  logic       c,
   input  logic       re,
   input  logic [1:0] mode,
   input  logic       d,
   input  logic       sr_in,   // value arriving on a right shift
   input  logic       sl_in,   // value arriving on a left shift
   output logic       q
);

   // Bit storage: reset wins over every mode.
   always_ff @(posedge c) begin
      if (re) begin
         q <= 1'b0;
      end else begin
         case (mode)
            MODE_HOLD: q <= q;
            MODE_SHR:  q <= sr_in;
            MODE_SHL:  q <= sl_in;
            MODE_LOAD: q <= d;
         endcase
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with a saturating count of shifts since the last load or reset.
// Optional feature: define UNIV_SHIFT_REG_ROTATE_EN to add the rot input,
// which turns both shifts into rotates (serial inputs ignored).
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                      c,
   input  logic                      re,
   input  logic [1:0]                mode,
   input  logic [WIDTH-1:0]          d,
   input  logic                      sir,
   input  logic                      sil,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
   input  logic                      rot,
`endif
   output logic [WIDTH-1:0]          q,
   output logic [WIDTH-1:0]          q_,
   output logic                      sor,
   output logic                      sol,
   output logic [cnt_w(WIDTH)-1:0]   cnt,
   output logic                      cnt_full
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   logic shr_msb;   // bit entering WIDTH-1 on a right shift
   logic shl_lsb;   // bit entering 0 on a left shift

   // Serial entry selection: rotate recirculates the outgoing bit.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
   always_comb begin
      shr_msb = rot ? q[0]       : sir;
      shl_lsb = rot ? q[WIDTH-1] : sil;
   end
`else
   always_comb begin
      shr_msb = sir;
      shl_lsb = sil;
   end
`endif

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_cell
         logic sr_in, sl_in;
         if (i == WIDTH - 1) begin : g_msb
            assign sr_in = shr_msb;
         end else begin : g_nmsb
            assign sr_in = q[i+1];
         end
         if (i == 0) begin : g_lsb
            assign sl_in = shl_lsb;
         end else begin : g_nlsb
            assign sl_in = q[i-1];
         end
         shreg_cell u_cell (
            .c     (c),
            .re    (re),
            .mode  (mode),
            .d     (d[i]),
            .sr_in (sr_in),
            .sl_in (sl_in),
            .q     (q[i])
         );
      end
   endgenerate

   // Shift counter: cleared by reset or load, saturates at WIDTH.
   always_ff @(posedge c) begin
      if (re) begin
         cnt <= '0;
      end else begin
         case (mode)
            MODE_LOAD: cnt <= '0;
            MODE_SHR,
            MODE_SHL:  if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            default:   cnt <= cnt;
         endcase
      end
   end

   // Derived outputs, all purely from registered state.
   always_comb begin
      q_       = ~q;
      sor      = q[0];
      sol      = q[WIDTH-1];
      cnt_full = (cnt == CNT_MAX);
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed scenarios plus
// randomized traffic compared against an arithmetic reference model.
module tb_univ_shift_reg;

   logic       c = 1'b0;
   logic       re = 1'b1;
   logic [1:0] mode = 2'b00;
   logic [7:0] d = 8'h00;
   logic       sir = 1'b0;
   logic       sil = 1'b0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
   logic       rot = 1'b0;
`endif
   logic [7:0] q, q_;
   logic       sor, sol;
   logic [3:0] cnt;
   logic       cnt_full;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_q;
   int m_cnt;

   univ_shift_reg #(.WIDTH(8)) dut (
      .c(c), .re(re), .mode(mode), .d(d), .sir(sir), .sil(sil),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      .rot(rot),
`endif
      .q(q), .q_(q_), .sor(sor), .sol(sol), .cnt(cnt), .cnt_full(cnt_full)
   );

   always #5 c = ~c;

   // Drive one cycle, advance past the edge, update the model.
   task automatic apply(input logic r, input logic [1:0] m, input logic [7:0] dd,
                        input logic si_r, input logic si_l, input logic rt);
      int b;
      logic rt_eff;
      re = r; mode = m; d = dd; sir = si_r; sil = si_l;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      rot = rt;
      rt_eff = rt;
`else
      rt_eff = 1'b0 & rt;
`endif
      @(posedge c); #1;
      if (r) begin
         m_q = 0; m_cnt = 0;
      end else if (m == 2'd1) begin
         b = rt_eff ? (m_q % 2) : int'(si_r);
         m_q = (m_q / 2) + b * 128;
         if (m_cnt < 8) m_cnt++;
      end else if (m == 2'd2) begin
         b = rt_eff ? (m_q / 128) : int'(si_l);
         m_q = (m_q * 2 + b) % 256;
         if (m_cnt < 8) m_cnt++;
      end else if (m == 2'd3) begin
         m_q = int'(dd); m_cnt = 0;
      end
   endtask

   task automatic test_reset();
      apply(1'b1, 2'b11, 8'hFF, 1'b1, 1'b1, 1'b0);
      total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
      total++; if (q_ !== 8'hFF) begin bad++; $display("FAIL reset_qn got=%h exp=FF", q_); end
      total++; if (sor !== 1'b0 || sol !== 1'b0) begin bad++; $display("FAIL reset_so got=%b%b exp=00", sol, sor); end
      total++; if (cnt !== 4'd0 || cnt_full !== 1'b0) begin bad++; $display("FAIL reset_cnt got=%0d/%b exp=0/0", cnt, cnt_full); end
   endtask

   task automatic test_shift_right();
      apply(1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) apply(1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
      total++; if (q !== 8'hF4) begin bad++; $display("FAIL shr_q got=%h exp=F4", q); end
      total++; if (sor !== 1'b0 || sol !== 1'b1) begin bad++; $display("FAIL shr_so got=%b%b exp=10", sol, sor); end
      total++; if (cnt !== 4'd3) begin bad++; $display("FAIL shr_cnt got=%0d exp=3", cnt); end
   endtask

   task automatic test_shift_left_sat();
      int exp_q, exp_c;
      apply(1'b0, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         apply(1'b0, 2'b10, 8'hFF, 1'b1, 1'b0, 1'b0);
         exp_q = (32'h81 << k) & 32'hFF;
         exp_c = (k < 8) ? k : 8;
         total++;
         if (int'(q) != exp_q || int'(cnt) != exp_c || cnt_full !== (k >= 8)) begin
            bad++;
            $display("FAIL shl_sat[%0d] got q=%h cnt=%0d full=%b exp q=%h cnt=%0d full=%b",
                     k, q, cnt, cnt_full, exp_q[7:0], exp_c, (k >= 8));
         end
      end
      // A load must drop cnt_full on the very next cycle.
      apply(1'b0, 2'b11, 8'h0F, 1'b0, 1'b0, 1'b0);
      total++; if (cnt !== 4'd0 || cnt_full !== 1'b0) begin bad++; $display("FAIL load_clear got=%0d/%b exp=0/0", cnt, cnt_full); end
   endtask

   task automatic test_hold();
      apply(1'b0, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         apply(1'b0, 2'b00, 8'($urandom), k[0], ~k[0], 1'b0);
         total++;
         if (q !== 8'h3C || cnt !== 4'd0 || q_ !== 8'hC3) begin
            bad++; $display("FAIL hold[%0d] got q=%h cnt=%0d exp q=3C cnt=0", k, q, cnt);
         end
      end
   endtask

`ifdef UNIV_SHIFT_REG_ROTATE_EN
   task automatic test_rotate();
      apply(1'b0, 2'b11, 8'h01, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b1);
      total++; if (q !== 8'h80 || cnt !== 4'd1) begin bad++; $display("FAIL rot_r got q=%h cnt=%0d exp q=80 cnt=1", q, cnt); end
      apply(1'b0, 2'b10, 8'h00, 1'b1, 1'b0, 1'b1);
      apply(1'b0, 2'b10, 8'h00, 1'b1, 1'b0, 1'b1);
      total++; if (q !== 8'h02 || cnt !== 4'd3) begin bad++; $display("FAIL rot_l got q=%h cnt=%0d exp q=02 cnt=3", q, cnt); end
   endtask
`endif

   task automatic test_reset_mid();
      apply(1'b0, 2'b11, 8'h55, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) apply(1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
      total++; if (q !== 8'h5F || cnt !== 4'd4) begin bad++; $display("FAIL mid_pre got q=%h cnt=%0d exp q=5F cnt=4", q, cnt); end
      apply(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
      total++; if (q !== 8'h00 || cnt !== 4'd0) begin bad++; $display("FAIL mid_rst got q=%h cnt=%0d exp q=00 cnt=0", q, cnt); end
      apply(1'b0, 2'b11, 8'h12, 1'b0, 1'b0, 1'b0);
      total++; if (q !== 8'h12 || cnt !== 4'd0) begin bad++; $display("FAIL mid_load got q=%h cnt=%0d exp q=12 cnt=0", q, cnt); end
   endtask

   task automatic test_random();
      logic [7:0] eq;
      for (int k = 0; k < 300; k++) begin
         apply(($urandom_range(0, 19) == 0), 2'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
         eq = 8'(m_q);
         total++;
         if (q !== eq || q_ !== ~eq || sor !== eq[0] || sol !== eq[7] ||
             int'(cnt) != m_cnt || cnt_full !== (m_cnt == 8)) begin
            bad++;
            $display("FAIL random[%0d] got q=%h qn=%h so=%b%b cnt=%0d full=%b exp q=%h cnt=%0d",
                     k, q, q_, sol, sor, cnt, cnt_full, eq, m_cnt);
         end
      end
   endtask

   initial begin
      m_q = 0; m_cnt = 0;
      test_reset();
      test_shift_right();
      test_shift_left_sat();
      test_hold();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      test_rotate();
`endif
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
